card_dealer: RTL and testbench

- Consumer end of the shuffled-deck stream. Accepts up to 52 shuffled card indices (0..51) through a valid/ready write interface and buffers them as a deck.
- Deals one card per request, in load order. Each dealt card comes out with its suit and its blackjack value.
- Sits between the shuffler and the blackjack game controller. Tracks how many cards remain and asks for a reshuffle when the deck runs low.

---
 rtl/blackjack_pkg.sv | 20 ++
 rtl/card_decode.sv | 41 ++++
 rtl/card_dealer.sv | 157 +++++++++++++++
 tb/tb_card_dealer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared blackjack constants: deck geometry, dealer states, suits.
// Imported by the dealer, the decoder and the game controller.
package blackjack_pkg;

  localparam int DECK_SIZE      = 52;
  localparam int CARDS_PER_SUIT = 13;
  localparam int NUM_CARDS      = 52;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_EMPTY = 2'd2
  } dealer_state_e;

  localparam logic [1:0] SUIT_CLUBS    = 2'd0;
  localparam logic [1:0] SUIT_DIAMONDS = 2'd1;
  localparam logic [1:0] SUIT_HEARTS   = 2'd2;
  localparam logic [1:0] SUIT_SPADES   = 2'd3;

endpackage

// File: rtl/card_decode.sv
// Card index to suit and blackjack value.
// Purely combinational; also reused for hand scoring.
module card_decode
  import blackjack_pkg::*;
(
  input  logic [5:0] card,
  output logic [1:0] suit,
  output logic [3:0] value
);

  localparam logic [5:0] S1 = 6'(CARDS_PER_SUIT);
  localparam logic [5:0] S2 = 6'(2 * CARDS_PER_SUIT);
  localparam logic [5:0] S3 = 6'(3 * CARDS_PER_SUIT);

  logic [5:0] base;
  logic [5:0] rank;

  // Suit by range compare, rank as offset into the suit.
  always_comb begin
    suit = SUIT_CLUBS;
    base = 6'd0;
    if (card >= S3) begin
      suit = SUIT_SPADES;
      base = S3;
    end else if (card >= S2) begin
      suit = SUIT_HEARTS;
      base = S2;
    end else if (card >= S1) begin
      suit = SUIT_DIAMONDS;
      base = S1;
    end
    rank = card - base;
    if (rank == 6'd0)
      value = 4'd1;
    else if (rank >= 6'd9)
      value = 4'd10;
    else
      value = rank[3:0] + 4'd1;
  end

endmodule

// File: rtl/card_dealer.sv
// Buffers one shuffled deck and deals it card by card.
// Flags load errors and asks for a reshuffle when low.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int DECK_SIZE           = blackjack_pkg::DECK_SIZE,
  parameter int RESHUFFLE_THRESHOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reload,
  input  logic       load_valid,
  input  logic [5:0] load_card,
  output logic       load_ready,
  output logic       load_error,
  input  logic       deal_req,
  output logic       card_valid,
  output logic [5:0] card,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       deck_ready,
  output logic       deck_empty,
  output logic       reshuffle_req
);

  localparam logic [5:0] DS  = 6'(DECK_SIZE);
  localparam logic [5:0] THR = 6'(RESHUFFLE_THRESHOLD);
  localparam logic [5:0] NC  = 6'(NUM_CARDS);

  dealer_state_e state_q, state_d;
  logic [5:0]  wr_ptr_q, wr_ptr_d;
  logic [5:0]  rd_ptr_q, rd_ptr_d;
  logic [63:0] seen_q, seen_d;
  logic        load_error_q, load_error_d;
  logic        card_valid_q, card_valid_d;
  logic [5:0]  card_q, card_d;
  logic [1:0]  suit_q, suit_d;
  logic [3:0]  value_q, value_d;

  logic [5:0] deck_q [DECK_SIZE];
  logic       wr_en;
  logic [5:0] rd_card;
  logic [1:0] dec_suit;
  logic [3:0] dec_value;

  assign rd_card = deck_q[rd_ptr_q];

  card_decode u_decode (
    .card  (rd_card),
    .suit  (dec_suit),
    .value (dec_value)
  );

  // Next-state: reload wins, then load or deal by state.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    seen_d       = seen_q;
    load_error_d = load_error_q;
    card_valid_d = 1'b0;
    card_d       = card_q;
    suit_d       = suit_q;
    value_d      = value_q;
    wr_en        = 1'b0;
    if (reload) begin
      state_d      = ST_LOAD;
      wr_ptr_d     = 6'd0;
      rd_ptr_d     = 6'd0;
      seen_d       = '0;
      load_error_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (load_valid) begin
            if (load_card >= NC || seen_q[load_card]) begin
              load_error_d = 1'b1;
            end else begin
              wr_en             = 1'b1;
              seen_d[load_card] = 1'b1;
              wr_ptr_d          = wr_ptr_q + 6'd1;
              if (wr_ptr_d == DS)
                state_d = ST_READY;
            end
          end
        end
        ST_READY: begin
          if (deal_req) begin
            card_valid_d = 1'b1;
            card_d       = rd_card;
            suit_d       = dec_suit;
            value_d      = dec_value;
            rd_ptr_d     = rd_ptr_q + 6'd1;
            if (rd_ptr_d == DS)
              state_d = ST_EMPTY;
          end
        end
        ST_EMPTY: begin
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= 6'd0;
      rd_ptr_q     <= 6'd0;
      seen_q       <= '0;
      load_error_q <= 1'b0;
      card_valid_q <= 1'b0;
      card_q       <= 6'd0;
      suit_q       <= 2'd0;
      value_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      seen_q       <= seen_d;
      load_error_q <= load_error_d;
      card_valid_q <= card_valid_d;
      card_q       <= card_d;
      suit_q       <= suit_d;
      value_q      <= value_d;
    end
  end

  // Deck storage; contents only matter once written.
  always_ff @(posedge clk) begin
    if (wr_en)
      deck_q[wr_ptr_q] <= load_card;
  end

  // Remaining count derived from the pointers.
  always_comb begin
    unique case (state_q)
      ST_LOAD:  cards_left = wr_ptr_q;
      ST_READY: cards_left = DS - rd_ptr_q;
      default:  cards_left = 6'd0;
    endcase
  end

  assign load_ready    = (state_q == ST_LOAD);
  assign load_error    = load_error_q;
  assign card_valid    = card_valid_q;
  assign card          = card_q;
  assign card_suit     = suit_q;
  assign card_value    = value_q;
  assign deck_ready    = (state_q == ST_READY);
  assign deck_empty    = (state_q == ST_EMPTY);
  assign reshuffle_req = (deck_ready && cards_left < THR)
                       || deck_empty;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer against a
// queue-based model of the deck.
module tb_card_dealer;

  localparam int DS  = 52;
  localparam int THR = 15;

  logic       clk = 1'b0;
  logic       rst, reload, load_valid, deal_req;
  logic [5:0] load_card;
  logic       load_ready, load_error, card_valid;
  logic [5:0] card, cards_left;
  logic [1:0] card_suit;
  logic [3:0] card_value;
  logic       deck_ready, deck_empty, reshuffle_req;

  always #5 clk = ~clk;

  card_dealer #(.DECK_SIZE(DS), .RESHUFFLE_THRESHOLD(THR)) dut (
    .clk           (clk),
    .rst           (rst),
    .reload        (reload),
    .load_valid    (load_valid),
    .load_card     (load_card),
    .load_ready    (load_ready),
    .load_error    (load_error),
    .deal_req      (deal_req),
    .card_valid    (card_valid),
    .card          (card),
    .card_suit     (card_suit),
    .card_value    (card_value),
    .cards_left    (cards_left),
    .deck_ready    (deck_ready),
    .deck_empty    (deck_empty),
    .reshuffle_req (reshuffle_req)
  );

  int checks   = 0;
  int failures = 0;

  // Model: 0 = loading, 1 = dealing, 2 = exhausted.
  int m_st;
  int m_deck[$];
  bit m_seen[64];
  int m_rd;
  bit m_err;
  bit m_cv;
  int m_card;
  int perm[DS];

  function automatic int bj_value(int c);
    int r = c % 13;
    if (r == 0) return 1;
    if (r >= 9) return 10;
    return r + 1;
  endfunction

  function automatic int exp_left();
    if (m_st == 0) return m_deck.size();
    if (m_st == 1) return DS - m_rd;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int left = exp_left();
    chk("load_ready", 32'(load_ready), 32'(m_st == 0));
    chk("load_error", 32'(load_error), 32'(m_err));
    chk("card_valid", 32'(card_valid), 32'(m_cv));
    chk("card", 32'(card), 32'(m_card));
    chk("card_suit", 32'(card_suit), 32'(m_card / 13));
    chk("card_value", 32'(card_value),
        m_card == 0 && m_cv == 0 && card_value == 0 ? 32'd0
                                                    : 32'(bj_value(m_card)));
    chk("cards_left", 32'(cards_left), 32'(left));
    chk("deck_ready", 32'(deck_ready), 32'(m_st == 1));
    chk("deck_empty", 32'(deck_empty), 32'(m_st == 2));
    chk("reshuffle_req", 32'(reshuffle_req),
        32'((m_st == 1 && left < THR) || m_st == 2));
  endtask

  task automatic model_reset();
    m_st = 0;
    m_deck.delete();
    foreach (m_seen[i]) m_seen[i] = 1'b0;
    m_rd  = 0;
    m_err = 1'b0;
    m_cv  = 1'b0;
  endtask

  // One clock: drive, advance model, sample after the edge.
  task automatic cyc(input bit r, input bit rl, input bit lv,
                     input int lc, input bit dr);
    rst        = r;
    reload     = rl;
    load_valid = lv;
    load_card  = 6'(lc);
    deal_req   = dr;
    if (r) begin
      model_reset();
      m_card = 0;
    end else if (rl) begin
      model_reset();
    end else begin
      m_cv = 1'b0;
      if (m_st == 0 && lv) begin
        if (lc > 51 || m_seen[lc]) begin
          m_err = 1'b1;
        end else begin
          m_seen[lc] = 1'b1;
          m_deck.push_back(lc);
          if (m_deck.size() == DS) m_st = 1;
        end
      end else if (m_st == 1 && dr) begin
        m_cv   = 1'b1;
        m_card = m_deck[m_rd];
        m_rd++;
        if (m_rd == DS) m_st = 2;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic shuffle();
    for (int i = 0; i < DS; i++) perm[i] = i;
    for (int i = DS - 1; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
  endtask

  task automatic load_perm(input int from);
    for (int i = from; i < DS; i++) cyc(0, 0, 1, perm[i], 0);
  endtask

  task automatic deal(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; reload = 1'b0; load_valid = 1'b0;
    load_card = 6'd0; deal_req = 1'b0;
    m_card = 0;
    model_reset();

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // In-order deck, then 53 consecutive requests.
    for (int i = 0; i < DS; i++) cyc(0, 0, 1, i, 0);
    deal(DS + 1);
    chk("empty_after_53", 32'(deck_empty), 32'd1);

    // Duplicate and out-of-range cards are dropped.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 52, 0);
    for (int i = 2; i < DS; i++) cyc(0, 0, 1, i, 0);
    deal(3);
    chk("dup_third_card", 32'(card), 32'd2);

    // deal_req ignored while loading.
    cyc(0, 1, 0, 0, 0);
    shuffle();
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, perm[i], 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("left_in_load", 32'(cards_left), 32'd10);
    load_perm(10);

    // Threshold edge.
    deal(37);
    chk("left_37", 32'(cards_left), 32'd15);
    chk("resh_37", 32'(reshuffle_req), 32'd0);
    deal(1);
    chk("resh_38", 32'(reshuffle_req), 32'd1);

    // reload coincident with deal_req.
    cyc(0, 1, 0, 0, 0);
    shuffle();
    load_perm(0);
    deal(5);
    cyc(0, 1, 0, 0, 1);
    shuffle();
    load_perm(0);
    deal(1);
    chk("fresh_first", 32'(card), 32'(perm[0]));

    // Reset in the middle of dealing.
    deal(21);
    chk("left_30", 32'(cards_left), 32'd30);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      bit rl = ($urandom_range(299, 0) == 0);
      bit lv = $urandom_range(1, 0) == 1;
      int lc = $urandom_range(55, 0);
      bit dr = $urandom_range(2, 0) != 0;
      cyc(0, rl, lv, lc, dr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
